// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command sequencer driving one combinational ALU
// Owns a 4-entry register file; one command in flight, response held until consumed.
module alu_op_sequencer #(
  parameter int word_length = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [1:0]             cmd_rd,
  input  logic [1:0]             cmd_rs1,
  input  logic [1:0]             cmd_rs2,
  input  logic [word_length-1:0] cmd_imm,
  output logic [word_length-1:0] alu_a,
  output logic [word_length-1:0] alu_b,
  output logic [1:0]             alu_control,
  input  logic [word_length:0]   alu_c,
  input  logic                   alu_zero,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [word_length-1:0] rsp_data,
  output logic                   rsp_carry,
  output logic                   rsp_zero,
  output logic                   rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] OP_LOADI = 3'b100;

  state_t                 state_q, state_d;
  logic [word_length-1:0] regs_q [4];
  logic [word_length-1:0] regs_d [4];
  logic [word_length-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]             alu_control_q, alu_control_d;
  logic [1:0]             rd_q, rd_d;
  logic [word_length-1:0] rsp_data_q, rsp_data_d;
  logic                   rsp_carry_q, rsp_carry_d;
  logic                   rsp_zero_q, rsp_zero_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   accept;

  assign accept = cmd_valid && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid) state_d = cmd_op[2] ? RESP : EXEC;
      EXEC: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
  end

  // Datapath: operand capture at accept, writeback either at accept (load-immediate) or in EXEC.
  always_comb begin
    regs_d        = regs_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_control_d = alu_control_q;
    rd_d          = rd_q;
    rsp_data_d    = rsp_data_q;
    rsp_carry_d   = rsp_carry_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_err_d     = rsp_err_q;
    if (accept) begin
      if (!cmd_op[2]) begin
        alu_a_d       = regs_q[cmd_rs1];
        alu_b_d       = regs_q[cmd_rs2];
        alu_control_d = cmd_op[1:0];
        rd_d          = cmd_rd;
      end else if (cmd_op == OP_LOADI) begin
        regs_d[cmd_rd] = cmd_imm;
        rsp_data_d     = cmd_imm;
        rsp_carry_d    = 1'b0;
        rsp_zero_d     = (cmd_imm == '0);
        rsp_err_d      = 1'b0;
      end else begin
        rsp_data_d  = '0;
        rsp_carry_d = 1'b0;
        rsp_zero_d  = 1'b1;
        rsp_err_d   = 1'b1;
      end
    end else if (state_q == EXEC) begin
      regs_d[rd_q] = alu_c[word_length-1:0];
      rsp_data_d   = alu_c[word_length-1:0];
      rsp_carry_d  = alu_c[word_length];
      rsp_zero_d   = alu_zero;
      rsp_err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_control_q <= '0;
      rd_q          <= '0;
      rsp_data_q    <= '0;
      rsp_carry_q   <= 1'b0;
      rsp_zero_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_control_q <= alu_control_d;
      rd_q          <= rd_d;
      rsp_data_q    <= rsp_data_d;
      rsp_carry_q   <= rsp_carry_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_control_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_carry   = rsp_carry_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
// Directed scenarios followed by random commands against a register-file reference model.
module tb_alu_op_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [1:0]   cmd_rd, cmd_rs1, cmd_rs2;
  logic [W-1:0] cmd_imm;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0]   alu_control;
  logic [W:0]   alu_c;
  logic         alu_zero;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_carry, rsp_zero, rsp_err;

  int checks = 0;
  int errors = 0;
  int mregs[4];
  int m_a, m_b, m_ctl;

  always #5 clk = ~clk;

  alu_op_sequencer #(.word_length(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_c(alu_c), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // The ALU the sequencer drives
  always_comb begin
    case (alu_control)
      2'b00:   alu_c = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_c = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   alu_c = {1'b0, alu_a & alu_b};
      default: alu_c = {1'b0, alu_a | alu_b};
    endcase
    alu_zero = (alu_c == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_ctl"}, alu_control, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_carry"}, rsp_carry, 0);
    check({tag, "_rsp_zero"}, rsp_zero, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    m_a = 0; m_b = 0; m_ctl = 0;
  endtask

  // Issues one command from a negedge in IDLE, holds the response `hold` cycles, then consumes it.
  task automatic run_cmd(input int op, input int rd, input int rs1, input int rs2,
                         input int imm, input int hold);
    int e_data, e_carry, e_zero, e_err, e_lat, r, a, b, lat;
    if (op < 4) begin
      a = mregs[rs1];
      b = mregs[rs2];
      case (op)
        0:       r = a + b;
        1:       r = (a - b) & 'h1FF;
        2:       r = a & b;
        default: r = a | b;
      endcase
      e_data = r & 'hFF; e_carry = (r >> 8) & 1; e_zero = (r == 0) ? 1 : 0; e_err = 0; e_lat = 2;
      mregs[rd] = e_data;
      m_a = a; m_b = b; m_ctl = op;
    end else if (op == 4) begin
      e_data = imm; e_carry = 0; e_zero = (imm == 0) ? 1 : 0; e_err = 0; e_lat = 1;
      mregs[rd] = imm;
    end else begin
      e_data = 0; e_carry = 0; e_zero = 1; e_err = 1; e_lat = 1;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op[2:0]; cmd_rd = rd[1:0]; cmd_rs1 = rs1[1:0]; cmd_rs2 = rs2[1:0]; cmd_imm = imm[W-1:0];
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_rd = 2'($urandom); cmd_rs1 = 2'($urandom);
    cmd_rs2 = 2'($urandom); cmd_imm = W'($urandom);
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, e_lat);
    for (int i = 0; i <= hold; i++) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, e_data);
      check("rsp_carry", rsp_carry, e_carry);
      check("rsp_zero", rsp_zero, e_zero);
      check("rsp_err", rsp_err, e_err);
      check("cmd_ready_busy", cmd_ready, 0);
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_control", alu_control, m_ctl);
      if (i == hold) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    check("rsp_valid_after", rsp_valid, 0);
    check("cmd_ready_after", cmd_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // load-immediate then add with carry, then add of a register to itself
    run_cmd(4, 0, 0, 0, 'hF0, 0);
    run_cmd(4, 1, 0, 0, 'h20, 0);
    run_cmd(0, 2, 0, 1, 0, 0);
    run_cmd(0, 3, 2, 2, 0, 0);

    // sub with borrow, then sub to zero
    run_cmd(4, 0, 0, 0, 5, 0);
    run_cmd(4, 1, 0, 0, 7, 0);
    run_cmd(1, 2, 0, 1, 0, 0);
    run_cmd(1, 3, 0, 0, 0, 0);

    // backpressure on an and
    run_cmd(4, 0, 0, 0, 'hCC, 0);
    run_cmd(4, 1, 0, 0, 'hAA, 0);
    run_cmd(2, 2, 0, 1, 0, 5);

    // illegal op leaves registers untouched
    run_cmd(6, 1, 2, 3, 'h55, 0);
    for (int i = 0; i < 4; i++) run_cmd(3, i, i, i, 0, 0);

    // reset while EXEC of or r2 = r0 | r1
    run_cmd(4, 0, 0, 0, 'h0F, 0);
    run_cmd(4, 1, 0, 0, 'h30, 0);
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale_rsp", rsp_valid, 0);
    end
    run_cmd(3, 2, 2, 2, 0, 0);

    for (int n = 0; n < 150; n++) begin
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
